// File: rtl/fht_but_pkg.sv
// Shared constants for the Hartley butterfly datapath.
package fht_but_pkg;

   // Default signed data word width (binary point is transparent to the block).
   localparam int D_BIT = 22;
   // Default signed twiddle width.
   localparam int W_BIT = 16;
   // Twiddle unity gain: -MAX_W is exactly -1.0, +1.0 is approximated by MAX_W-1.
   localparam int MAX_W = 1 << (W_BIT - 1);
   // Data full-scale magnitude.
   localparam int MAX_D = 1 << (D_BIT - 1);
   // Allowed output error against the ideal real-valued result, in LSBs.
   localparam int ACC_LIMIT = 1;

   // Full-precision width for each product and for their sum (one guard bit).
   function automatic int prod_bits(input int d_bit, input int w_bit);
      return d_bit + w_bit + 1;
   endfunction

endpackage

// File: rtl/fht_but_rot.sv
// Stage 1 of the butterfly: rotation multiply-add T = round((cos*x1 + sin*x2) / MAX_W).
// T is held one bit wider than the data because |T| can reach ~1.414x full scale.
module fht_but_rot #(
   parameter int D_BIT = fht_but_pkg::D_BIT,
   parameter int W_BIT = fht_but_pkg::W_BIT
) (
   input  logic                    iCLK,
   input  logic                    iRESET,
   input  logic signed [D_BIT-1:0] iX_1,
   input  logic signed [D_BIT-1:0] iX_2,
   input  logic signed [W_BIT-1:0] iCOS,
   input  logic signed [W_BIT-1:0] iSIN,
   output logic signed [D_BIT:0]   oT
);

   localparam int P_BIT = fht_but_pkg::prod_bits(D_BIT, W_BIT);

   // Half an output LSB at the product scale, for round-half-up.
   localparam logic signed [P_BIT-1:0] HALF_W = P_BIT'(1) <<< (W_BIT - 2);

   localparam logic signed [D_BIT:0] T_MAX = {1'b0, {D_BIT{1'b1}}};
   localparam logic signed [D_BIT:0] T_MIN = {1'b1, {D_BIT{1'b0}}};

   logic signed [P_BIT-1:0] p_cos;
   logic signed [P_BIT-1:0] p_sin;
   logic signed [P_BIT-1:0] acc;
   logic signed [P_BIT-1:0] acc_rnd;
   logic signed [D_BIT+1:0] t_full;
   logic signed [D_BIT:0]   t_sat;
   logic signed [D_BIT:0]   t_q;

   // Full-precision products and sum, rounded and scaled back by MAX_W.
   always_comb begin
      p_cos   = P_BIT'(iCOS) * P_BIT'(iX_1);
      p_sin   = P_BIT'(iSIN) * P_BIT'(iX_2);
      acc     = p_cos + p_sin;
      acc_rnd = acc + HALF_W;
      // Arithmetic shift by W_BIT-1 is the part-select of the upper bits.
      t_full  = acc_rnd[P_BIT-1:W_BIT-1];
   end

   // Clamp T to D_BIT+1 bits; only reachable with out-of-range coefficient pairs.
   always_comb begin
      t_sat = t_full[D_BIT:0];
      if (t_full[D_BIT+1] != t_full[D_BIT]) begin
         t_sat = t_full[D_BIT+1] ? T_MIN : T_MAX;
      end
   end

   // Stage-1 register of T.
   always_ff @(posedge iCLK or negedge iRESET) begin
      if (!iRESET) begin
         t_q <= '0;
      end else begin
         t_q <= t_sat;
      end
   end

   assign oT = t_q;

endmodule

// File: rtl/fht_but.sv
// Hartley butterfly with 1/2 per-stage scaling, two-stage pipeline:
//   Y0 = round((X0 + T) / 2), Y1 = round((X0 - T) / 2), T from fht_but_rot.
// X0 is sampled one edge after X1/X2/coefficients so that both outputs line up.
module fht_but #(
   parameter int D_BIT = fht_but_pkg::D_BIT,
   parameter int W_BIT = fht_but_pkg::W_BIT
) (
   input  logic                    iCLK,
   input  logic                    iRESET,
   input  logic signed [D_BIT-1:0] iX_0,
   input  logic signed [D_BIT-1:0] iX_1,
   input  logic signed [D_BIT-1:0] iX_2,
   input  logic signed [W_BIT-1:0] iCOS,
   input  logic signed [W_BIT-1:0] iSIN,
   output logic signed [D_BIT-1:0] oY_0,
   output logic signed [D_BIT-1:0] oY_1
);

   localparam int S_BIT = D_BIT + 2;

   localparam logic signed [D_BIT-1:0] Y_MAX = {1'b0, {(D_BIT-1){1'b1}}};
   localparam logic signed [D_BIT-1:0] Y_MIN = {1'b1, {(D_BIT-1){1'b0}}};

   logic signed [D_BIT:0]   t;
   logic signed [S_BIT-1:0] x0_ext;
   logic signed [S_BIT-1:0] t_ext;
   logic signed [S_BIT-1:0] sum;
   logic signed [S_BIT-1:0] dif;
   logic signed [S_BIT-1:0] sum_rnd;
   logic signed [S_BIT-1:0] dif_rnd;
   logic signed [D_BIT:0]   sum_half;
   logic signed [D_BIT:0]   dif_half;
   logic signed [D_BIT-1:0] y0_d;
   logic signed [D_BIT-1:0] y1_d;
   logic signed [D_BIT-1:0] y0_q;
   logic signed [D_BIT-1:0] y1_q;

   fht_but_rot #(
      .D_BIT (D_BIT),
      .W_BIT (W_BIT)
   ) u_rot (
      .iCLK   (iCLK),
      .iRESET (iRESET),
      .iX_1   (iX_1),
      .iX_2   (iX_2),
      .iCOS   (iCOS),
      .iSIN   (iSIN),
      .oT     (t)
   );

   // Sum/difference at D_BIT+2 bits, halved with round-half-up.
   always_comb begin
      x0_ext   = S_BIT'(iX_0);
      t_ext    = S_BIT'(t);
      sum      = x0_ext + t_ext;
      dif      = x0_ext - t_ext;
      sum_rnd  = sum + S_BIT'(1);
      dif_rnd  = dif + S_BIT'(1);
      sum_half = sum_rnd[S_BIT-1:1];
      dif_half = dif_rnd[S_BIT-1:1];
   end

   // Saturate the halved results to the data range instead of wrapping.
   always_comb begin
      y0_d = sum_half[D_BIT-1:0];
      y1_d = dif_half[D_BIT-1:0];
      if (sum_half[D_BIT] != sum_half[D_BIT-1]) begin
         y0_d = sum_half[D_BIT] ? Y_MIN : Y_MAX;
      end
      if (dif_half[D_BIT] != dif_half[D_BIT-1]) begin
         y1_d = dif_half[D_BIT] ? Y_MIN : Y_MAX;
      end
   end

   // Stage-2 output registers.
   always_ff @(posedge iCLK or negedge iRESET) begin
      if (!iRESET) begin
         y0_q <= '0;
         y1_q <= '0;
      end else begin
         y0_q <= y0_d;
         y1_q <= y1_d;
      end
   end

   assign oY_0 = y0_q;
   assign oY_1 = y1_q;

endmodule

// File: tb/tb_fht_but.sv
// Directed bench for fht_but plus a streaming random regression against a real-valued model.
module tb_fht_but;

   localparam int D_BIT = 22;
   localparam int W_BIT = 16;
   localparam int DMAX  = 2097151;
   localparam int DMIN  = -2097152;
   localparam int N_REG = 2000;

   logic                    clk = 1'b0;
   logic                    rst_n;
   logic signed [D_BIT-1:0] x0, x1, x2;
   logic signed [W_BIT-1:0] cs, sn;
   logic signed [D_BIT-1:0] y0, y1;

   int checks = 0;
   int errors = 0;

   int ang_c [8] = '{32767, 23170, 0, -23170, -32767, -23170, 0, 23170};
   int ang_s [8] = '{0, 23170, 32767, 23170, 0, -23170, -32767, -23170};
   int dat_a [4] = '{DMAX, DMAX, -DMAX, -DMAX};
   int dat_b [4] = '{DMAX, -DMAX, DMAX, -DMAX};

   int r_x0 [N_REG];
   int r_x1 [N_REG];
   int r_x2 [N_REG];
   int r_c  [N_REG];
   int r_s  [N_REG];

   always #5 clk = ~clk;

   fht_but #(
      .D_BIT (D_BIT),
      .W_BIT (W_BIT)
   ) dut (
      .iCLK   (clk),
      .iRESET (rst_n),
      .iX_0   (x0),
      .iX_1   (x1),
      .iX_2   (x2),
      .iCOS   (cs),
      .iSIN   (sn),
      .oY_0   (y0),
      .oY_1   (y1)
   );

   task automatic drive(input int a0, input int a1, input int a2, input int c, input int s);
      x0 = D_BIT'(a0);
      x1 = D_BIT'(a1);
      x2 = D_BIT'(a2);
      cs = W_BIT'(c);
      sn = W_BIT'(s);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check_eq(input string tag, input int got, input int exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Ideal real-valued butterfly output, clamped to the data range.
   function automatic real ideal(input int a0, input int a1, input int a2, input int c,
                                 input int s, input bit diff);
      real t, y;
      t = (real'(c) * real'(a1) + real'(s) * real'(a2)) / 32768.0;
      y = diff ? (real'(a0) - t) / 2.0 : (real'(a0) + t) / 2.0;
      if (y > real'(DMAX)) y = real'(DMAX);
      if (y < real'(DMIN)) y = real'(DMIN);
      return y;
   endfunction

   function automatic bit is_sat(input int a0, input int a1, input int a2, input int c,
                                 input int s);
      real t;
      t = (real'(c) * real'(a1) + real'(s) * real'(a2)) / 32768.0;
      return ((real'(a0) + t) / 2.0 > real'(DMAX)) || ((real'(a0) + t) / 2.0 < real'(DMIN))
          || ((real'(a0) - t) / 2.0 > real'(DMAX)) || ((real'(a0) - t) / 2.0 < real'(DMIN));
   endfunction

   task automatic check_tol(input string tag, input int got, input real exp, output real err);
      err = real'(got) - exp;
      if (err < 0.0) err = -err;
      checks++;
      assert (err <= real'(fht_but_pkg::ACC_LIMIT)) else begin
         errors++;
         $error("FAIL %s: got %0d expected %f", tag, got, exp);
      end
   endtask

   initial begin
      real e0, e1, max_err, sum_err;
      int  sat_cnt, ovf_cnt, err_cnt, start_err;

      // Reset held with non-zero inputs keeps outputs at zero.
      rst_n = 1'b0;
      drive(1234, -5678, 999, 20000, -12000);
      step();
      step();
      step();
      check_eq("reset_y0", int'(y0), 0);
      check_eq("reset_y1", int'(y1), 0);

      // Cos-only rotation; X0 follows one clock after X1/X2/coefficients.
      rst_n = 1'b1;
      drive(777, 1000, 1000, 32767, 0);
      step();
      drive(0, 5, -7, 0, 100);
      step();
      check_eq("cos_only_y0", int'(y0), 500);
      check_eq("cos_only_y1", int'(y1), -500);

      // Sine path with zero weighted operand.
      drive(2000, 1000, 0, 0, 32767);
      step();
      step();
      check_eq("sin_zero_y0", int'(y0), 1000);
      check_eq("sin_zero_y1", int'(y1), 1000);

      // -MAX_W is exactly -1.0 on both coefficient inputs.
      drive(0, 1000, 0, -32768, 0);
      step();
      step();
      check_eq("cos_m1_y0", int'(y0), -500);
      check_eq("cos_m1_y1", int'(y1), 500);
      drive(0, 0, 1000, 0, -32768);
      step();
      step();
      check_eq("sin_m1_y0", int'(y0), -500);
      check_eq("sin_m1_y1", int'(y1), 500);

      // Positive and negative saturation, no wrap.
      drive(DMAX, DMAX, DMAX, 23170, 23170);
      step();
      step();
      check_eq("sat_pos_y0", int'(y0), DMAX);
      check_eq("sat_pos_y1", int'(y1), -434304);
      drive(DMIN, DMIN, DMIN, 23170, 23170);
      step();
      step();
      check_eq("sat_neg_y0", int'(y0), DMIN);
      check_eq("sat_neg_y1", int'(y1), 434304);

      // Mid-operation reset clears outputs at once and discards the in-flight T.
      drive(0, 1000, 1000, 32767, 0);
      step();
      #2 rst_n = 1'b0;
      #1;
      check_eq("async_rst_y0", int'(y0), 0);
      check_eq("async_rst_y1", int'(y1), 0);
      drive(0, 0, 0, 0, 0);
      #2 rst_n = 1'b1;
      step();
      check_eq("flush_y0", int'(y0), 0);
      check_eq("flush_y1", int'(y1), 0);

      // Special angles k*45 degrees over +/- full-scale operand pairs.
      sat_cnt = 0;
      for (int k = 0; k < 8; k++) begin
         for (int d = 0; d < 4; d++) begin
            drive(0, dat_a[d], dat_b[d], ang_c[k], ang_s[k]);
            step();
            step();
            if (is_sat(0, dat_a[d], dat_b[d], ang_c[k], ang_s[k])) sat_cnt++;
            check_tol("angle_y0", int'(y0), ideal(0, dat_a[d], dat_b[d], ang_c[k], ang_s[k], 1'b0),
                      e0);
            check_tol("angle_y1", int'(y1), ideal(0, dat_a[d], dat_b[d], ang_c[k], ang_s[k], 1'b1),
                      e1);
         end
      end
      $display("special angles: %0d cases flagged saturated", sat_cnt);

      // Streaming random regression, one butterfly per clock.
      for (int i = 0; i < N_REG; i++) begin
         r_x0[i] = int'($urandom_range(4194303)) - 2097152;
         r_x1[i] = int'($urandom_range(4194303)) - 2097152;
         r_x2[i] = int'($urandom_range(4194303)) - 2097152;
         r_c[i]  = int'($urandom_range(46340)) - 23170;
         r_s[i]  = int'($urandom_range(46340)) - 23170;
      end
      max_err   = 0.0;
      sum_err   = 0.0;
      ovf_cnt   = 0;
      start_err = errors;
      for (int j = 0; j <= N_REG; j++) begin
         if (j < N_REG) begin
            x1 = D_BIT'(r_x1[j]);
            x2 = D_BIT'(r_x2[j]);
            cs = W_BIT'(r_c[j]);
            sn = W_BIT'(r_s[j]);
         end
         x0 = (j >= 1) ? D_BIT'(r_x0[j-1]) : '0;
         step();
         if (j >= 1) begin
            int i;
            i = j - 1;
            if (is_sat(r_x0[i], r_x1[i], r_x2[i], r_c[i], r_s[i])) ovf_cnt++;
            check_tol("rand_y0", int'(y0),
                      ideal(r_x0[i], r_x1[i], r_x2[i], r_c[i], r_s[i], 1'b0), e0);
            check_tol("rand_y1", int'(y1),
                      ideal(r_x0[i], r_x1[i], r_x2[i], r_c[i], r_s[i], 1'b1), e1);
            if (e0 > max_err) max_err = e0;
            if (e1 > max_err) max_err = e1;
            sum_err = sum_err + e0 + e1;
         end
      end
      err_cnt = errors - start_err;
      $display("regression: sets %0d errors %0d overflows %0d max_err %f avg_err %f",
               N_REG, err_cnt, ovf_cnt, max_err, sum_err / real'(2 * N_REG));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
